// File: rtl/audio_pkg.sv
// rtl/audio_pkg.sv - shared audio sample widths and types
package audio_pkg;
    localparam int ADC_W    = 12;
    localparam int SAMPLE_W = 16;

    typedef logic signed [SAMPLE_W-1:0] sample_t;
endpackage

// File: rtl/sat_shift.sv
// rtl/sat_shift.sv - signed left shift with saturation to out_w bits
module sat_shift #(
    parameter int in_w  = 13,
    parameter int out_w = 16,
    parameter int shift = 3
) (
    input  logic signed [in_w-1:0]  v_in,
    output logic signed [out_w-1:0] v_out
);
    // One spare bit above whichever is wider keeps the shifted value exact.
    localparam int EW = ((in_w + shift > out_w) ? (in_w + shift) : out_w) + 1;

    localparam logic signed [EW-1:0] SAT_MAX = {{(EW-out_w+1){1'b0}}, {(out_w-1){1'b1}}};
    localparam logic signed [EW-1:0] SAT_MIN = {{(EW-out_w+1){1'b1}}, {(out_w-1){1'b0}}};

    logic signed [EW-1:0] ext;

    always_comb begin
        ext = {{(EW-in_w){v_in[in_w-1]}}, v_in} <<< shift;
        if (ext > SAT_MAX) begin
            v_out = SAT_MAX[out_w-1:0];
        end else if (ext < SAT_MIN) begin
            v_out = SAT_MIN[out_w-1:0];
        end else begin
            v_out = ext[out_w-1:0];
        end
    end
endmodule

// File: rtl/adc_dc_blocker.sv
// rtl/adc_dc_blocker.sv - ADC offset-binary capture, leaky-integrator DC removal, gain and saturate
module adc_dc_blocker
    import audio_pkg::*;
#(
    parameter int in_width   = ADC_W,
    parameter int out_width  = SAMPLE_W,
    parameter int shift_k    = 10,
    parameter int gain_shift = 3
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    input  logic [in_width-1:0]         sample_in,
    input  logic                        bypass,
    output logic                        out_valid,
    output logic signed [out_width-1:0] sample_out,
    output logic                        primed
);
    localparam int ACC_W = in_width + shift_k + 1;
    localparam int Y_W   = in_width + 1;

    logic                        valid1_q, valid1_d;
    logic signed [in_width-1:0]  x_q, x_d;
    logic                        bypass1_q, bypass1_d;
    logic signed [ACC_W-1:0]     acc_q, acc_d;
    logic                        primed_q, primed_d;
    logic                        out_valid_q, out_valid_d;
    logic signed [out_width-1:0] sample_out_q, sample_out_d;

    logic signed [ACC_W-1:0]     x_ext;
    logic signed [ACC_W-1:0]     dc;
    logic signed [ACC_W-1:0]     y_full;
    logic signed [Y_W-1:0]       v;
    logic signed [out_width-1:0] sat_out;

    always_comb begin
        valid1_d  = in_valid;
        x_d       = x_q;
        bypass1_d = bypass1_q;
        if (in_valid) begin
            x_d       = {~sample_in[in_width-1], sample_in[in_width-2:0]};
            bypass1_d = bypass;
        end

        x_ext    = {{(ACC_W-in_width){x_q[in_width-1]}}, x_q};
        dc       = acc_q >>> shift_k;
        acc_d    = acc_q;
        primed_d = primed_q;
        y_full   = '0;
        // The tracker keeps running in bypass so leaving bypass is glitch-free.
        if (valid1_q) begin
            if (!primed_q) begin
                acc_d    = x_ext <<< shift_k;
                primed_d = 1'b1;
            end else begin
                y_full = x_ext - dc;
                acc_d  = acc_q + y_full;
            end
        end

        v = bypass1_q ? {x_q[in_width-1], x_q} : y_full[Y_W-1:0];
    end

    sat_shift #(
        .in_w  (Y_W),
        .out_w (out_width),
        .shift (gain_shift)
    ) u_sat_shift (
        .v_in  (v),
        .v_out (sat_out)
    );

    always_comb begin
        out_valid_d  = valid1_q;
        sample_out_d = valid1_q ? sat_out : sample_out_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid1_q     <= 1'b0;
            x_q          <= '0;
            bypass1_q    <= 1'b0;
            acc_q        <= '0;
            primed_q     <= 1'b0;
            out_valid_q  <= 1'b0;
            sample_out_q <= '0;
        end else begin
            valid1_q     <= valid1_d;
            x_q          <= x_d;
            bypass1_q    <= bypass1_d;
            acc_q        <= acc_d;
            primed_q     <= primed_d;
            out_valid_q  <= out_valid_d;
            sample_out_q <= sample_out_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign sample_out = sample_out_q;
    assign primed     = primed_q;
endmodule

// File: tb/tb_adc_dc_blocker.sv
// tb/tb_adc_dc_blocker.sv - directed self-checking bench for adc_dc_blocker
module tb_adc_dc_blocker;
    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               in_valid = 1'b1;
    logic [11:0]        sample_in = 12'h000;
    logic               bypass = 1'b0;
    logic               out_valid, out_valid4;
    logic signed [15:0] sample_out, sample_out4;
    logic               primed, primed4;

    int total = 0;
    int bad = 0;
    int lat_err = 0;
    logic exp1 = 1'b0;
    logic exp2 = 1'b0;

    int out_q[$];
    int out4_q[$];
    int exp_q[$];
    longint m_acc = 0;
    bit m_primed = 1'b0;

    always #5 clk = ~clk;

    adc_dc_blocker dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .sample_in(sample_in), .bypass(bypass),
        .out_valid(out_valid), .sample_out(sample_out), .primed(primed)
    );

    adc_dc_blocker #(.gain_shift(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .sample_in(sample_in), .bypass(bypass),
        .out_valid(out_valid4), .sample_out(sample_out4), .primed(primed4)
    );

    // Expected out_valid: two cycles after an accepted in_valid, killed by reset on either edge.
    always @(posedge clk) begin
        exp2 <= exp1 && !rst;
        exp1 <= in_valid && !rst;
    end

    always @(negedge clk) begin
        if (out_valid !== exp2) lat_err++;
        if (out_valid4 !== exp2) lat_err++;
        if (out_valid === 1'b1) out_q.push_back(int'(sample_out));
        if (out_valid4 === 1'b1) out4_q.push_back(int'(sample_out4));
    end

    function automatic int model_out(input int s, input bit byp);
        longint x, dc, y, v, w;
        x = longint'(s) - 2048;
        y = 0;
        if (!m_primed) begin
            m_acc    = x * 1024;
            m_primed = 1'b1;
        end else begin
            dc    = m_acc >>> 10;
            y     = x - dc;
            m_acc = m_acc + y;
        end
        v = byp ? x : y;
        w = v * 8;
        if (w > 32767) w = 32767;
        if (w < -32768) w = -32768;
        return int'(w);
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        m_acc = 0;
        m_primed = 1'b0;
        out_q.delete();
        out4_q.delete();
        exp_q.delete();
    endtask

    task automatic send(input int s, input bit b);
        @(negedge clk);
        in_valid = 1'b1;
        sample_in = s[11:0];
        bypass = b;
        exp_q.push_back(model_out(s, b));
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (n - 1) @(negedge clk);
    endtask

    task automatic drain();
        idle(5);
        #1;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%0b want=0", out_valid); end
        total++; if (sample_out !== 16'sd0) begin bad++; $display("FAIL reset_sample_out got=%0d want=0", sample_out); end
        total++; if (primed !== 1'b0 || primed4 !== 1'b0) begin bad++; $display("FAIL reset_primed got=%0b/%0b want=0", primed, primed4); end
        rst = 1'b0;
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        total++; if (out_q.size() != 0 || primed !== 1'b0) begin bad++; $display("FAIL reset_coincident_valid outs=%0d primed=%0b want 0/0", out_q.size(), primed); end
    endtask

    task automatic test_zero_stream();
        int nz = 0;
        do_reset();
        for (int i = 0; i < 100; i++) begin
            send(12'h800, 1'b0);
            idle(3);
            if (i == 0) begin
                #1;
                total++; if (primed !== 1'b1) begin bad++; $display("FAIL zero_primed got=%0b want=1", primed); end
            end
        end
        drain();
        total++; if (out_q.size() != 100) begin bad++; $display("FAIL zero_count got=%0d want=100", out_q.size()); end
        foreach (out_q[i]) if (out_q[i] != 0) nz++;
        total++; if (nz != 0) begin bad++; $display("FAIL zero_values nonzero=%0d want=0", nz); end
        total++; if (lat_err != 0) begin bad++; $display("FAIL zero_latency errs=%0d want=0", lat_err); end
    endtask

    task automatic test_step();
        int nonmono = 0;
        int mism = 0;
        do_reset();
        send(12'h800, 1'b0);
        for (int i = 0; i < 8192; i++) send(12'hC00, 1'b0);
        drain();
        total++; if (out_q.size() != 8193) begin bad++; $display("FAIL step_count got=%0d want=8193", out_q.size()); end
        if (out_q.size() == 8193) begin
            total++; if (out_q[0] != 0) begin bad++; $display("FAIL step_prime got=%0d want=0", out_q[0]); end
            total++; if (out_q[1] != 8192) begin bad++; $display("FAIL step_first got=%0d want=8192", out_q[1]); end
            total++; if (out_q[2] != 8184) begin bad++; $display("FAIL step_second got=%0d want=8184", out_q[2]); end
            for (int i = 2; i < 8193; i++) if (out_q[i] > out_q[i-1]) nonmono++;
            total++; if (nonmono != 0) begin bad++; $display("FAIL step_monotonic rises=%0d want=0", nonmono); end
            total++; if (out_q[1024] < 2998 || out_q[1024] > 3030) begin bad++; $display("FAIL step_1024 got=%0d want=3014+-16", out_q[1024]); end
            total++; if (out_q[8192] > 8 || out_q[8192] < 0) begin bad++; $display("FAIL step_8192 got=%0d want=0..8", out_q[8192]); end
            for (int i = 0; i < 8193; i++) if (out_q[i] != exp_q[i]) mism++;
            total++; if (mism != 0) begin bad++; $display("FAIL step_model diffs=%0d want=0", mism); end
        end
    endtask

    task automatic test_gain_sat();
        do_reset();
        send(12'h000, 1'b0);
        for (int i = 0; i < 2048; i++) send(12'hFFF, 1'b0);
        send(12'h000, 1'b0);
        send(12'h000, 1'b0);
        drain();
        total++; if (out4_q.size() != 2051 || out_q.size() != 2051) begin bad++; $display("FAIL sat_count got=%0d/%0d want=2051", out4_q.size(), out_q.size()); end
        if (out4_q.size() == 2051 && out_q.size() == 2051) begin
            total++; if (out4_q[1] != 32767) begin bad++; $display("FAIL sat_pos got=%0d want=32767", out4_q[1]); end
            total++; if (out4_q[2049] != -32768 || out4_q[2050] != -32768) begin bad++; $display("FAIL sat_neg got=%0d,%0d want=-32768", out4_q[2049], out4_q[2050]); end
            total++; if (out_q[1] != 32760) begin bad++; $display("FAIL sat_gain3_edge got=%0d want=32760", out_q[1]); end
            total++; if (out_q[2049] != exp_q[2049]) begin bad++; $display("FAIL sat_gain3_neg got=%0d want=%0d", out_q[2049], exp_q[2049]); end
        end
    endtask

    task automatic test_bypass();
        int nconst = 0;
        do_reset();
        send(12'h800, 1'b1);
        for (int i = 0; i < 2048; i++) send(12'hC00, 1'b1);
        send(12'hC00, 1'b0);
        drain();
        total++; if (out_q.size() != 2050) begin bad++; $display("FAIL byp_count got=%0d want=2050", out_q.size()); end
        if (out_q.size() == 2050) begin
            for (int i = 1; i <= 2048; i++) if (out_q[i] != 8192) nconst++;
            total++; if (nconst != 0) begin bad++; $display("FAIL byp_const diffs=%0d want=0", nconst); end
            total++; if (out_q[2049] != exp_q[2049]) begin bad++; $display("FAIL byp_release got=%0d want=%0d", out_q[2049], exp_q[2049]); end
            total++; if (out_q[2049] < 1050 || out_q[2049] > 1170) begin bad++; $display("FAIL byp_release_range got=%0d want=1050..1170", out_q[2049]); end
        end
    endtask

    task automatic test_back_to_back();
        int mism = 0;
        do_reset();
        for (int i = 0; i < 200; i++) send(int'($urandom_range(0, 4095)), bit'($urandom_range(0, 1)));
        drain();
        total++; if (out_q.size() != 200) begin bad++; $display("FAIL b2b_count got=%0d want=200", out_q.size()); end
        if (out_q.size() == 200) begin
            for (int i = 0; i < 200; i++) if (out_q[i] != exp_q[i]) mism++;
            total++; if (mism != 0) begin bad++; $display("FAIL b2b_model diffs=%0d want=0", mism); end
        end
        total++; if (lat_err != 0) begin bad++; $display("FAIL b2b_latency errs=%0d want=0", lat_err); end
    endtask

    task automatic test_mid_reset();
        out_q.delete();
        @(negedge clk);
        in_valid = 1'b1;
        sample_in = 12'h123;
        @(negedge clk);
        sample_in = 12'h456;
        rst = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b0;
        #1;
        total++; if (sample_out !== 16'sd0 || primed !== 1'b0) begin bad++; $display("FAIL midrst_state got=%0d/%0b want=0/0", sample_out, primed); end
        repeat (3) @(negedge clk);
        #1;
        total++; if (out_q.size() != 0) begin bad++; $display("FAIL midrst_dropped outs=%0d want=0", out_q.size()); end
        m_acc = 0;
        m_primed = 1'b0;
        exp_q.delete();
        send(12'hA00, 1'b0);
        drain();
        total++; if (out_q.size() != 1 || primed !== 1'b1) begin bad++; $display("FAIL midrst_reprime outs=%0d primed=%0b want=1/1", out_q.size(), primed); end
        if (out_q.size() == 1) begin
            total++; if (out_q[0] != 0) begin bad++; $display("FAIL midrst_value got=%0d want=0", out_q[0]); end
        end
        total++; if (lat_err != 0) begin bad++; $display("FAIL midrst_latency errs=%0d want=0", lat_err); end
    endtask

    initial begin
        test_reset();
        test_zero_stream();
        test_step();
        test_gain_sat();
        test_bypass();
        test_back_to_back();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/adc_dc_blocker.md
Name: adc_dc_blocker

Overview:
Front-end conditioning stage between the on-chip ADC and effects_pipline. It captures 12-bit offset-binary ADC samples on a valid strobe and converts them to two's complement. It removes the guitar pickup/bias DC offset with a first-order leaky-integrator high-pass, then scales and saturates the result to the 16-bit signed effects word. Output is a registered sample plus a one-cycle valid pulse.

Parameters:
in_width, 12, ADC sample width (offset binary).
out_width, 16, signed output sample width.
shift_k, 10, DC-tracker pole: dc estimate = acc >>> shift_k; corner ≈ fs/(2π·2^shift_k).
gain_shift, 3, left shift applied to filtered sample before saturation.

Ports:
clk  in  1  system clock (50 MHz domain).
rst  in  1  synchronous, active-high reset.
in_valid  in  1  one-cycle strobe: sample_in holds a new ADC result.
sample_in  in  in_width  unsigned ADC sample, mid-scale = 2^(in_width-1).
bypass  in  1  1 = skip DC removal (scale + saturate only); sampled with in_valid.
out_valid  out  1  one-cycle strobe: sample_out updated.
sample_out  out  out_width  signed filtered sample.
primed  out  1  high once the first sample after reset has seeded the tracker.

Behaviour:
- Reset is synchronous and active-high: out_valid=0, sample_out=0, primed=0, accumulator=0, all pipeline regs and valids=0.
- Stage 1 (cycle N+1 after in_valid at N): x = sample_in with MSB inverted, as a signed in_width value. Register x and bypass, and delay the valid. 0x800→0, 0xFFF→+2047, 0x000→−2048.
- Stage 2 (cycle N+2): dc = acc >>> shift_k (arithmetic). y = x − dc, computed at in_width+1 bits with no overflow possible.
  - Accumulator update: acc <= acc + y. acc width = in_width+shift_k+1, signed.
  - First valid after reset (primed=0): acc <= x << shift_k, y is forced to 0, and primed <= 1 on the same edge.
- Output: if bypass, v = x sign-extended; else v = y. v is shifted left by gain_shift, saturated to [−2^(out_width-1), 2^(out_width-1)−1], and registered to sample_out.
- out_valid pulses for exactly 1 cycle, 2 cycles after in_valid. sample_out holds its value between pulses.
- The accumulator updates on every valid sample, including in bypass, so clearing bypass does not produce a DC transient.
- Back-to-back in_valid on every clock is supported at full throughput. Gaps in in_valid produce no out_valid and no state change.
- rst asserted mid-operation: in-flight samples are dropped, no out_valid pulses during or on the cycle after reset, and priming restarts.
- in_valid coincident with rst is ignored.

Decomposition:
- Shared package (audio_pkg): ADC_W=12, SAMPLE_W=16, and a sample_t signed typedef, reused by effects_pipline and the output path.
- One sub-module: sat_shift (signed left shift + saturate to out_width, combinational). The same unit is needed by the gain stage.
- Offset-binary conversion is inline (MSB inversion); no separate module.

Test Plan:
1. Reset, then 100 samples of 0x800 every 4 cycles → all sample_out=0; primed=1 after the first; each out_valid exactly 2 cycles after in_valid.
2. Prime at 0x800, then step to 0xC00 continuously:
   - first output 8192;
   - second output 8184 (acc=1024, dc=1, y=1023);
   - output monotonically decays, ≈3014±16 after 1024 samples and ≤8 after 8192 samples.
3. Parameter gain_shift=4, prime at 0x000, step to 0xFFF → first output saturates to 0x7FFF. Step back to 0x000 → 0x8000 (−32768), no wrap.
4. Same step as scenario 2 with bypass=1 → constant 8192 and no decay. Drop bypass after 2048 samples → next output ≈ (1024−dc)·8 matching the accumulator model, no jump to 8192.
5. Continuous in_valid every cycle, random samples vs. reference model → bit-exact match, one out_valid per input, no drops.
6. Assert rst for 1 cycle with 2 samples in flight → no out_valid for those samples, sample_out=0, primed=0. Next sample re-primes (output 0).
